// File: rtl/wb_bus_arbiter.sv
// Two-master to one-slave Wishbone B4 classic arbiter with round-robin grant
// and a per-transaction watchdog that forces err on a stuck slave.
module wb_bus_arbiter #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction master
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [XLEN-1:0]   i_dat_w,
  input  logic [XLEN/8-1:0] i_sel,
  output logic [XLEN-1:0]   i_dat_r,
  output logic              i_ack,
  output logic              i_err,
  // data master
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [XLEN-1:0]   d_dat_w,
  input  logic [XLEN/8-1:0] d_sel,
  output logic [XLEN-1:0]   d_dat_r,
  output logic              d_ack,
  output logic              d_err,
  // shared slave
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [XLEN-1:0]   s_dat_w,
  output logic [XLEN/8-1:0] s_sel,
  input  logic [XLEN-1:0]   s_dat_r,
  input  logic              s_ack,
  input  logic              s_err,
  output logic [1:0]        grant
);

  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] TO_VAL = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;     // 0 = instruction, 1 = data
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [1:0]      grant_q, grant_d;

  logic g_cyc, g_stb, timeout;

  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    if (state_q == GNT_I) begin
      g_cyc = i_cyc;
      g_stb = i_stb;
    end else if (state_q == GNT_D) begin
      g_cyc = d_cyc;
      g_stb = d_stb;
    end
  end

  assign timeout = (state_q != IDLE) && g_stb && !s_ack && !s_err && (wdog_q == TO_VAL);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = '0;
    case (state_q)
      IDLE: begin
        if (i_cyc && d_cyc) state_d = last_q ? GNT_I : GNT_D;
        else if (i_cyc)     state_d = GNT_I;
        else if (d_cyc)     state_d = GNT_D;
      end
      default: begin
        if (!g_cyc || timeout) begin
          state_d = IDLE;
          last_d  = (state_q == GNT_D);
        end else if (g_stb && !s_ack && !s_err) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
    endcase
    grant_d = {state_d == GNT_D, state_d == GNT_I};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      wdog_q  <= '0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;

  // On a watchdog expiry the slave strobe is withdrawn and err is forced instead.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    i_dat_r = '0;
    i_ack   = 1'b0;
    i_err   = 1'b0;
    d_dat_r = '0;
    d_ack   = 1'b0;
    d_err   = 1'b0;
    case (state_q)
      GNT_I: begin
        s_cyc   = i_cyc & ~timeout;
        s_stb   = i_stb & ~timeout;
        s_we    = i_we;
        s_adr   = i_adr;
        s_dat_w = i_dat_w;
        s_sel   = i_sel;
        i_dat_r = s_dat_r;
        i_ack   = s_ack & i_stb;
        i_err   = (s_err & i_stb) | timeout;
      end
      GNT_D: begin
        s_cyc   = d_cyc & ~timeout;
        s_stb   = d_stb & ~timeout;
        s_we    = d_we;
        s_adr   = d_adr;
        s_dat_w = d_dat_w;
        s_sel   = d_sel;
        d_dat_r = s_dat_r;
        d_ack   = s_ack & d_stb;
        d_err   = (s_err & d_stb) | timeout;
      end
      default: ;
    endcase
  end

endmodule
